ps2_lynx_keyboard: RTL and testbench

PS2_LYNX_KEYBOARD -- requirements
Module: ps2_lynx_keyboard

---
 rtl/ps2_lynx_pkg.sv | 113 +++++++++++
 rtl/ps2_lynx_keyboard_ps2_rx.sv | 139 +++++++++++++
 rtl/ps2_lynx_keyboard.sv | 100 ++++++++++
 tb/tb_ps2_lynx_keyboard.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_lynx_pkg.sv
// Shared definitions for the PS/2 -> Camputers Lynx keyboard adapter.
//   rx_state_e  : PS/2 frame receiver states
//   key_loc_t   : result of a scan-code lookup (valid, matrix row, column)
//   key_lookup  : {extended, code} -> matrix position table
//   NUM_ROWS/NUM_COLS, prefix codes and the Pause skip length
package ps2_lynx_pkg;

  localparam int unsigned NUM_ROWS = 10;
  localparam int unsigned NUM_COLS = 8;

  localparam logic [7:0] CODE_EXT     = 8'hE0;
  localparam logic [7:0] CODE_PAUSE   = 8'hE1;
  localparam logic [7:0] CODE_RELEASE = 8'hF0;
  localparam logic [7:0] CODE_F12     = 8'h07;
  localparam logic [7:0] CODE_LSHIFT  = 8'h12;
  localparam logic [7:0] CODE_RSHIFT  = 8'h59;

  // Bytes that follow 0xE1 in the Pause make/break sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } key_loc_t;

  function automatic key_loc_t mk(input int unsigned row, input int unsigned col);
    key_loc_t loc;
    loc.valid = 1'b1;
    loc.row   = 4'(row);
    loc.col   = 3'(col);
    return loc;
  endfunction

  // Both Shift codes share row 0 col 0; the top module merges their states.
  function automatic key_loc_t key_lookup(input logic ext, input logic [7:0] code);
    key_loc_t loc;
    loc = '0;
    case ({ext, code})
      9'h012, 9'h059: loc = mk(0, 0);  // Shift
      9'h076: loc = mk(0, 1);          // Esc
      9'h172: loc = mk(0, 2);          // Down
      9'h029: loc = mk(0, 3);          // Space
      9'h175: loc = mk(0, 4);          // Up
      9'h058: loc = mk(0, 5);          // Caps Lock
      9'h016: loc = mk(0, 6);          // 1
      9'h01E: loc = mk(0, 7);          // 2
      9'h014: loc = mk(1, 0);          // Ctrl
      9'h026: loc = mk(1, 1);          // 3
      9'h025: loc = mk(1, 2);          // 4
      9'h024: loc = mk(1, 3);          // E
      9'h022: loc = mk(1, 4);          // X
      9'h023: loc = mk(1, 5);          // D
      9'h021: loc = mk(1, 6);          // C
      9'h077: loc = mk(1, 7);          // Num Lock
      9'h01A: loc = mk(2, 0);          // Z
      9'h01C: loc = mk(2, 1);          // A
      9'h01D: loc = mk(2, 2);          // W
      9'h015: loc = mk(2, 3);          // Q
      9'h01B: loc = mk(2, 4);          // S
      9'h02E: loc = mk(2, 5);          // 5
      9'h02D: loc = mk(2, 6);          // R
      9'h02B: loc = mk(2, 7);          // F
      9'h036: loc = mk(3, 0);          // 6
      9'h02C: loc = mk(3, 1);          // T
      9'h02A: loc = mk(3, 2);          // V
      9'h034: loc = mk(3, 3);          // G
      9'h032: loc = mk(3, 4);          // B
      9'h035: loc = mk(3, 5);          // Y
      9'h033: loc = mk(3, 6);          // H
      9'h03D: loc = mk(3, 7);          // 7
      9'h03C: loc = mk(4, 0);          // U
      9'h031: loc = mk(4, 1);          // N
      9'h03B: loc = mk(4, 2);          // J
      9'h03A: loc = mk(4, 3);          // M
      9'h03E: loc = mk(4, 4);          // 8
      9'h043: loc = mk(4, 5);          // I
      9'h042: loc = mk(4, 6);          // K
      9'h041: loc = mk(4, 7);          // ,
      9'h046: loc = mk(5, 0);          // 9
      9'h044: loc = mk(5, 1);          // O
      9'h04B: loc = mk(5, 2);          // L
      9'h049: loc = mk(5, 3);          // .
      9'h045: loc = mk(5, 4);          // 0
      9'h04D: loc = mk(5, 5);          // P
      9'h04C: loc = mk(5, 6);          // ;
      9'h04A: loc = mk(5, 7);          // /
      9'h04E: loc = mk(6, 0);          // -
      9'h054: loc = mk(6, 1);          // [
      9'h052: loc = mk(6, 2);          // '
      9'h05B: loc = mk(6, 3);          // ]
      9'h055: loc = mk(6, 4);          // =
      9'h05D: loc = mk(6, 5);          // backslash
      9'h05A: loc = mk(6, 6);          // Return
      9'h16B: loc = mk(6, 7);          // Left
      9'h174: loc = mk(7, 0);          // Right
      9'h066: loc = mk(7, 1);          // Delete (Backspace)
      9'h00D: loc = mk(7, 2);          // Tab
      9'h15A: loc = mk(8, 0);          // keypad Enter
      9'h005: loc = mk(9, 7);          // F1
      default: loc = '0;
    endcase
    return loc;
  endfunction

endpackage

// File: rtl/ps2_lynx_keyboard_ps2_rx.sv
// PS/2 frame receiver.
//   clock, reset_n     : system clock, async active-low reset
//   ps2_clk, ps2_dat   : raw PS/2 lines (asynchronous)
//   code               : last accepted byte
//   code_valid         : one-cycle pulse per good frame
//   frame_err          : one-cycle pulse per parity/stop/timeout discard
module ps2_rx
  import ps2_lynx_pkg::*;
#(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, dat_filt, clk_filt_q;
  logic [FW-1:0] clk_fcnt, dat_fcnt;
  logic          fall;

  rx_state_e     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Output follows the synchronised line only after FILTER consecutive
  // samples that differ from the current output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      clk_fcnt <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      clk_fcnt <= '0;
    end else if (clk_fcnt == FW'(FILTER - 1)) begin
      clk_filt <= clk_sync[1];
      clk_fcnt <= '0;
    end else begin
      clk_fcnt <= clk_fcnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dat_filt <= 1'b1;
      dat_fcnt <= '0;
    end else if (dat_sync[1] == dat_filt) begin
      dat_fcnt <= '0;
    end else if (dat_fcnt == FW'(FILTER - 1)) begin
      dat_filt <= dat_sync[1];
      dat_fcnt <= '0;
    end else begin
      dat_fcnt <= dat_fcnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) clk_filt_q <= 1'b1;
    else          clk_filt_q <= clk_filt;
  end

  assign fall = clk_filt_q & ~clk_filt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      idle_cnt   <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == ST_IDLE) begin
        idle_cnt <= '0;
        if (fall && !dat_filt) begin
          state   <= ST_DATA;
          bit_cnt <= '0;
        end
      end else if (!fall) begin
        if (idle_cnt == TW'(TIMEOUT - 1)) begin
          state     <= ST_IDLE;
          bit_cnt   <= '0;
          shreg     <= '0;
          idle_cnt  <= '0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
        case (state)
          ST_DATA: begin
            shreg   <= {dat_filt, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= dat_filt;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if ((^{shreg, par_bit}) && dat_filt) begin
              code       <= shreg;
              code_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_lynx_keyboard.sv
// PS/2 keyboard to Camputers Lynx key matrix adapter.
//   clock, reset_n : system clock, async active-low reset
//   ps2_clk/dat    : raw PS/2 lines
//   row_i          : row select from the Lynx core
//   keys_o         : active-low columns of the selected row (FF for rows 10-15)
//   key_reset_o    : high while F12 is held
//   scan_valid_o / scan_code_o / frame_err_o : receiver status
module ps2_lynx_keyboard
  import ps2_lynx_pkg::*;
#(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [3:0] row_i,
  output logic [7:0] keys_o,
  output logic       key_reset_o,
  output logic       scan_valid_o,
  output logic [7:0] scan_code_o,
  output logic       frame_err_o
);

  logic [7:0] rx_code;
  logic       rx_valid;

  logic [7:0] matrix [NUM_ROWS];
  logic       rel_flag, ext_flag;
  logic [2:0] skip_cnt;
  logic       shift_l_rel, shift_r_rel;
  key_loc_t   loc;
  logic       is_shift_l, is_shift_r;

  ps2_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .code       (rx_code),
    .code_valid (rx_valid),
    .frame_err  (frame_err_o)
  );

  assign scan_valid_o = rx_valid;
  assign scan_code_o  = rx_code;

  always_comb begin
    loc        = key_lookup(ext_flag, rx_code);
    is_shift_l = !ext_flag && (rx_code == CODE_LSHIFT);
    is_shift_r = !ext_flag && (rx_code == CODE_RSHIFT);
  end

  // The shared Shift bit is the AND of the two per-key release states, so
  // it reads released only once both physical keys are up.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NUM_ROWS; r++) matrix[r] <= '1;
      rel_flag    <= 1'b0;
      ext_flag    <= 1'b0;
      skip_cnt    <= '0;
      shift_l_rel <= 1'b1;
      shift_r_rel <= 1'b1;
      key_reset_o <= 1'b0;
    end else if (rx_valid) begin
      if (skip_cnt != '0) begin
        skip_cnt <= skip_cnt - 1'b1;
      end else if (rx_code == CODE_RELEASE) begin
        rel_flag <= 1'b1;
      end else if (rx_code == CODE_EXT) begin
        ext_flag <= 1'b1;
      end else if (rx_code == CODE_PAUSE) begin
        skip_cnt <= PAUSE_SKIP;
      end else begin
        if (!ext_flag && (rx_code == CODE_F12)) key_reset_o <= ~rel_flag;
        if (is_shift_l) begin
          shift_l_rel              <= rel_flag;
          matrix[loc.row][loc.col] <= rel_flag & shift_r_rel;
        end else if (is_shift_r) begin
          shift_r_rel              <= rel_flag;
          matrix[loc.row][loc.col] <= rel_flag & shift_l_rel;
        end else if (loc.valid) begin
          matrix[loc.row][loc.col] <= rel_flag;
        end
        rel_flag <= 1'b0;
        ext_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    keys_o = '1;
    if (row_i < 4'(NUM_ROWS)) keys_o = matrix[row_i];
  end

endmodule

// File: tb/tb_ps2_lynx_keyboard.sv
module tb_ps2_lynx_keyboard;

  localparam int unsigned FILTER  = 8;
  localparam int unsigned TIMEOUT = 300;
  localparam int          HALF    = 20;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [3:0] row_i = '0;
  logic [7:0] keys_o;
  logic       key_reset_o;
  logic       scan_valid_o;
  logic [7:0] scan_code_o;
  logic       frame_err_o;

  ps2_lynx_keyboard #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .row_i        (row_i),
    .keys_o       (keys_o),
    .key_reset_o  (key_reset_o),
    .scan_valid_o (scan_valid_o),
    .scan_code_o  (scan_code_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;

  // Scoreboard monitor: every valid/error pulse pops one expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && (scan_valid_o || frame_err_o)) begin
      if (scan_valid_o) n_valid++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got valid=%0b err=%0b code=%02h, required no event",
                 scan_valid_o, frame_err_o, scan_code_o);
      end else begin
        e = exp_q.pop_front();
        if (scan_valid_o && frame_err_o) begin
          n_fail++;
          $display("FAIL event_both: got valid and err together, required %s",
                   e.is_err ? "err" : "valid");
        end else if (e.is_err && !frame_err_o) begin
          n_fail++;
          $display("FAIL event_kind: got valid code=%02h, required frame_err", scan_code_o);
        end else if (!e.is_err && !scan_valid_o) begin
          n_fail++;
          $display("FAIL event_kind: got frame_err, required valid code=%02h", e.code);
        end else if (!e.is_err && scan_code_o !== e.code) begin
          n_fail++;
          $display("FAIL scan_code: got %02h, required %02h", scan_code_o, e.code);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_row(input int r, input logic [7:0] req);
    row_i = 4'(r);
    #1;
    check($sformatf("keys_row%0d", r), 32'(keys_o), 32'(req));
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par);
    exp_t e;
    e.is_err = bad_par;
    e.code   = d;
    exp_q.push_back(e);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ bad_par);
    ps2_bit(1'b1);
    wait_cyc(40);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b0);
  endtask

  int v0;

  initial begin
    wait_cyc(5);
    @(negedge clock);
    reset_n = 1'b1;
    wait_cyc(5);

    // Reset state
    for (int r = 0; r < 16; r++) check_row(r, 8'hFF);
    check("key_reset_init", 32'(key_reset_o), 32'd0);
    check("scan_code_init", 32'(scan_code_o), 32'h00);
    check("scan_valid_init", 32'(scan_valid_o), 32'd0);
    check("frame_err_init", 32'(frame_err_o), 32'd0);

    // A press / release
    v0 = n_valid;
    send(8'h1C);
    check_row(2, 8'hFD);
    send(8'hF0);
    send(8'h1C);
    check_row(2, 8'hFF);
    check("valid_count_A", 32'(n_valid - v0), 32'd3);

    // Bad parity on Space
    v0 = n_valid;
    send_frame(8'h29, 1'b1);
    check_row(0, 8'hFF);
    check("valid_count_badpar", 32'(n_valid - v0), 32'd0);

    // Partial frame then idle past timeout
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.code   = 8'h00;
      exp_q.push_back(e);
    end
    ps2_bit(1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(1'b1);
    wait_cyc(TIMEOUT + 60);
    check("timeout_drained", 32'(exp_q.size()), 32'd0);
    send(8'h29);
    check_row(0, 8'hF7);
    send(8'hF0);
    send(8'h29);
    check_row(0, 8'hFF);

    // Extended Up arrow; plain 0x75 is unmapped
    send(8'hE0);
    send(8'h75);
    check_row(0, 8'hEF);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_row(0, 8'hFF);
    send(8'h75);
    check_row(0, 8'hFF);

    // Two shifts share one bit
    send(8'h12);
    check_row(0, 8'hFE);
    send(8'h59);
    send(8'h12);
    check_row(0, 8'hFE);
    send(8'hF0);
    send(8'h12);
    check_row(0, 8'hFE);
    send(8'hF0);
    send(8'h59);
    check_row(0, 8'hFF);

    // F12 drives key_reset_o only
    send(8'h07);
    check("key_reset_make", 32'(key_reset_o), 32'd1);
    for (int r = 0; r < 10; r++) check_row(r, 8'hFF);
    send(8'hF0);
    send(8'h07);
    check("key_reset_break", 32'(key_reset_o), 32'd0);

    // Pause sequence is swallowed
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    for (int r = 0; r < 10; r++) check_row(r, 8'hFF);
    send(8'h1C);
    check_row(2, 8'hFD);

    // Reset in the middle of a frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_dat = 1'b1;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(5);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    for (int r = 0; r < 16; r++) check_row(r, 8'hFF);
    check("scan_code_rst", 32'(scan_code_o), 32'h00);
    check("frame_err_rst", 32'(frame_err_o), 32'd0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(10);
    @(negedge clock);
    reset_n = 1'b1;
    wait_cyc(30);

    // Fresh frame after reset
    send(8'h29);
    check_row(0, 8'hF7);
    check_row(2, 8'hFF);

    wait_cyc(50);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
